// File: rtl/mme_tile_scheduler.sv
// mme_tile_scheduler
//
// Breaks one N x N matrix-multiply command into a stream of SA_WIDTH x SA_WIDTH
// tile operations (ti outer, tj middle, tk inner). Each tile's A/B/C base byte
// addresses come from adds only and are issued over a valid/ready port. At most
// MAX_OUT tiles may be issued without a matching tile_done_i pulse.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start_i           command pulse, sampled only while idle
//   mat_dim_i         matrix dimension N, latched with start_i
//   mode_i            0 = overwrite C, 1 = accumulate into C, latched with start_i
//   mat_*_addr_i      row-major byte base addresses of A/B/C, latched with start_i
//   busy_o            command in progress
//   done_o            one-cycle completion pulse
//   err_o             sticky: last command had an illegal N
//   tile_valid_o      descriptor valid
//   tile_ready_i      datapath accepts the descriptor
//   tile_*_addr_o     tile base byte addresses
//   tile_first_k_o    first K-step of this C tile
//   tile_last_k_o     last K-step of this C tile
//   tile_load_c_o     preload C tile into the accumulators
//   tile_done_i       one-cycle pulse per completed tile
module mme_tile_scheduler #(
    parameter int unsigned SA_WIDTH = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned DIM_W    = 10,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DIM_W-1:0] mat_dim_i,
    input  logic             mode_i,
    input  logic [31:0]      mat_a_addr_i,
    input  logic [31:0]      mat_b_addr_i,
    input  logic [31:0]      mat_c_addr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             tile_valid_o,
    input  logic             tile_ready_i,
    output logic [31:0]      tile_a_addr_o,
    output logic [31:0]      tile_b_addr_o,
    output logic [31:0]      tile_c_addr_o,
    output logic             tile_first_k_o,
    output logic             tile_last_k_o,
    output logic             tile_load_c_o,
    input  logic             tile_done_i
);

    localparam int unsigned EB     = DW / 8;
    localparam int unsigned SA_LOG = $clog2(SA_WIDTH);
    localparam int unsigned OW     = $clog2(MAX_OUT + 1);
    // Byte step between horizontally adjacent tiles; also the per-N multiplier
    // of the vertical tile step (SA_WIDTH rows of N elements).
    localparam logic [31:0]      COL_STEP = 32'(SA_WIDTH * EB);
    localparam logic [DIM_W-1:0] SA_MASK  = DIM_W'(SA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StFin,
        StFail
    } state_e;

    state_e           state_q;
    logic [OW-1:0]    out_q;
    logic             mode_q;
    logic [DIM_W-1:0] t_last_q;
    logic [DIM_W-1:0] ti_q;
    logic [DIM_W-1:0] tj_q;
    logic [DIM_W-1:0] tk_q;
    logic [31:0]      row_step_q;
    logic [31:0]      a_row_q;    // a_base + ti*row_step
    logic [31:0]      b_base_q;
    logic [31:0]      b_col_q;    // b_base + tj*COL_STEP
    logic [31:0]      c_row_q;    // c_base + ti*row_step

    logic          hs;
    logic          dec;
    logic [OW-1:0] out_d;
    logic          slot_free;
    logic          n_legal;
    logic          tk_last;
    logic          tj_last;
    logic          ti_last;

    always_comb begin
        hs        = tile_valid_o & tile_ready_i;
        // A completion with nothing outstanding is stale (e.g. from before a reset).
        dec       = tile_done_i & (out_q != '0);
        out_d     = out_q + OW'(hs) - OW'(dec);
        // A completion this cycle frees a slot for the next cycle's valid.
        slot_free = out_d < OW'(MAX_OUT);
        n_legal   = (mat_dim_i != '0) && ((mat_dim_i & SA_MASK) == '0);
        tk_last   = tk_q == t_last_q;
        tj_last   = tj_q == t_last_q;
        ti_last   = ti_q == t_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            out_q          <= '0;
            mode_q         <= 1'b0;
            t_last_q       <= '0;
            ti_q           <= '0;
            tj_q           <= '0;
            tk_q           <= '0;
            row_step_q     <= '0;
            a_row_q        <= '0;
            b_base_q       <= '0;
            b_col_q        <= '0;
            c_row_q        <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            tile_valid_o   <= 1'b0;
            tile_a_addr_o  <= '0;
            tile_b_addr_o  <= '0;
            tile_c_addr_o  <= '0;
            tile_first_k_o <= 1'b0;
            tile_last_k_o  <= 1'b0;
            tile_load_c_o  <= 1'b0;
        end else begin
            out_q <= out_d;
            unique case (state_q)
                StIdle: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (n_legal) begin
                            state_q        <= StIssue;
                            err_o          <= 1'b0;
                            mode_q         <= mode_i;
                            t_last_q       <= (mat_dim_i >> SA_LOG) - DIM_W'(1);
                            ti_q           <= '0;
                            tj_q           <= '0;
                            tk_q           <= '0;
                            row_step_q     <= 32'(mat_dim_i) * COL_STEP;
                            a_row_q        <= mat_a_addr_i;
                            b_base_q       <= mat_b_addr_i;
                            b_col_q        <= mat_b_addr_i;
                            c_row_q        <= mat_c_addr_i;
                            // Nothing is outstanding while idle, so a slot is free.
                            tile_valid_o   <= 1'b1;
                            tile_a_addr_o  <= mat_a_addr_i;
                            tile_b_addr_o  <= mat_b_addr_i;
                            tile_c_addr_o  <= mat_c_addr_i;
                            tile_first_k_o <= 1'b1;
                            tile_last_k_o  <= mat_dim_i == DIM_W'(SA_WIDTH);
                            tile_load_c_o  <= mode_i;
                        end else begin
                            state_q <= StFail;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                        end
                    end
                end

                StIssue: begin
                    tile_valid_o <= slot_free;
                    if (hs) begin
                        if (!tk_last) begin
                            // Next K-step: walk A right, B down; C tile unchanged.
                            tk_q           <= tk_q + DIM_W'(1);
                            tile_a_addr_o  <= tile_a_addr_o + COL_STEP;
                            tile_b_addr_o  <= tile_b_addr_o + row_step_q;
                            tile_first_k_o <= 1'b0;
                            tile_last_k_o  <= (tk_q + DIM_W'(1)) == t_last_q;
                            tile_load_c_o  <= 1'b0;
                        end else if (!tj_last) begin
                            // Next C tile in the same row band.
                            tk_q           <= '0;
                            tj_q           <= tj_q + DIM_W'(1);
                            b_col_q        <= b_col_q + COL_STEP;
                            tile_a_addr_o  <= a_row_q;
                            tile_b_addr_o  <= b_col_q + COL_STEP;
                            tile_c_addr_o  <= tile_c_addr_o + COL_STEP;
                            tile_first_k_o <= 1'b1;
                            tile_last_k_o  <= t_last_q == '0;
                            tile_load_c_o  <= mode_q;
                        end else if (!ti_last) begin
                            // Next row band: restart B and C columns.
                            tk_q           <= '0;
                            tj_q           <= '0;
                            ti_q           <= ti_q + DIM_W'(1);
                            a_row_q        <= a_row_q + row_step_q;
                            b_col_q        <= b_base_q;
                            c_row_q        <= c_row_q + row_step_q;
                            tile_a_addr_o  <= a_row_q + row_step_q;
                            tile_b_addr_o  <= b_base_q;
                            tile_c_addr_o  <= c_row_q + row_step_q;
                            tile_first_k_o <= 1'b1;
                            tile_last_k_o  <= t_last_q == '0;
                            tile_load_c_o  <= mode_q;
                        end else begin
                            // Last tile accepted; descriptor outputs keep its value.
                            state_q      <= StDrain;
                            tile_valid_o <= 1'b0;
                        end
                    end
                end

                StDrain: begin
                    tile_valid_o <= 1'b0;
                    if (out_d == '0) begin
                        state_q <= StFin;
                        done_o  <= 1'b1;
                    end
                end

                StFin: begin
                    state_q <= StIdle;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end

                StFail: begin
                    state_q <= StIdle;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end

                default: begin
                    state_q      <= StIdle;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                    tile_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mme_tile_scheduler.sv
module tb_mme_tile_scheduler;

    localparam int SA      = 4;
    localparam int EB      = 4;
    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [9:0]  mat_dim_i;
    logic        mode_i;
    logic [31:0] mat_a_addr_i;
    logic [31:0] mat_b_addr_i;
    logic [31:0] mat_c_addr_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        tile_valid_o;
    logic        tile_ready_i;
    logic [31:0] tile_a_addr_o;
    logic [31:0] tile_b_addr_o;
    logic [31:0] tile_c_addr_o;
    logic        tile_first_k_o;
    logic        tile_last_k_o;
    logic        tile_load_c_o;
    logic        tile_done_i;

    int total_chk = 0;
    int bad_chk   = 0;

    // Descriptors captured at each handshake of the latest run_cmd call.
    logic [31:0] obs_a[$];
    logic [31:0] obs_b[$];
    logic [31:0] obs_c[$];
    logic        obs_lk[$];
    logic        obs_lc[$];

    mme_tile_scheduler #(
        .SA_WIDTH(SA),
        .DW      (32),
        .DIM_W   (10),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .mat_dim_i     (mat_dim_i),
        .mode_i        (mode_i),
        .mat_a_addr_i  (mat_a_addr_i),
        .mat_b_addr_i  (mat_b_addr_i),
        .mat_c_addr_i  (mat_c_addr_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .tile_valid_o  (tile_valid_o),
        .tile_ready_i  (tile_ready_i),
        .tile_a_addr_o (tile_a_addr_o),
        .tile_b_addr_o (tile_b_addr_o),
        .tile_c_addr_o (tile_c_addr_o),
        .tile_first_k_o(tile_first_k_o),
        .tile_last_k_o (tile_last_k_o),
        .tile_load_c_o (tile_load_c_o),
        .tile_done_i   (tile_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tile base address straight from the row-major layout.
    function automatic logic [31:0] taddr(input logic [31:0] base, input int row_t,
                                          input int col_t, input int n);
        return base + 32'(row_t * SA * n * EB) + 32'(col_t * SA * EB);
    endfunction

    task automatic start_cmd(input int n, input logic mode, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c);
        start_i      = 1'b1;
        mat_dim_i    = 10'(n);
        mode_i       = mode;
        mat_a_addr_i = a;
        mat_b_addr_i = b;
        mat_c_addr_i = c;
        tick();
        start_i = 1'b0;
    endtask

    // Runs one legal command against a queue-based model. abort_after >= 0 stops
    // (without reset) after that many handshakes; stall_idx holds ready low for
    // stall_len valid cycles on that tile; scramble toggles the latched inputs.
    task automatic run_cmd(input int n, input logic mode, input logic [31:0] ab,
                           input logic [31:0] bb, input logic [31:0] cb,
                           input int ready_pct, input int max_delay, input int abort_after,
                           input int stall_idx, input int stall_len, input bit scramble);
        logic [31:0] ea[$];
        logic [31:0] eb[$];
        logic [31:0] ec[$];
        logic        efk[$];
        logic        elk[$];
        logic        elc[$];
        int          due[$];
        int tt, ntiles, idx, outm, cyc, last_hs, last_due, stall_left, bad0;
        bit fin, exp_valid, exp_done, rdy, hs, dn;
        logic [31:0] hold_a;
        tt = n / SA;
        for (int ti = 0; ti < tt; ti++)
            for (int tj = 0; tj < tt; tj++)
                for (int tk = 0; tk < tt; tk++) begin
                    ea.push_back(taddr(ab, ti, tk, n));
                    eb.push_back(taddr(bb, tk, tj, n));
                    ec.push_back(taddr(cb, ti, tj, n));
                    efk.push_back(tk == 0);
                    elk.push_back(tk == tt - 1);
                    elc.push_back(mode && (tk == 0));
                end
        ntiles = ea.size();
        obs_a.delete(); obs_b.delete(); obs_c.delete(); obs_lk.delete(); obs_lc.delete();
        start_cmd(n, mode, ab, bb, cb);
        idx = 0; outm = 0; cyc = 1; last_hs = -100; last_due = 0; fin = 0;
        stall_left = stall_len; hold_a = '0; bad0 = bad_chk;
        while (!fin && cyc < 4000 && (bad_chk - bad0) <= 20) begin
            exp_valid = (idx < ntiles) && (outm < MAX_OUT);
            exp_done  = (idx == ntiles) && (cyc >= last_hs + 2) && (outm == 0);
            total_chk++;
            if (tile_valid_o !== exp_valid) begin
                bad_chk++;
                $display("FAIL valid n=%0d cyc=%0d got=%b want=%b", n, cyc, tile_valid_o,
                         exp_valid);
            end
            total_chk++;
            if (done_o !== exp_done) begin
                bad_chk++;
                $display("FAIL done n=%0d cyc=%0d got=%b want=%b", n, cyc, done_o, exp_done);
            end
            total_chk++;
            if ({busy_o, err_o} !== 2'b10) begin
                bad_chk++;
                $display("FAIL busy_err n=%0d cyc=%0d got=%b want=10", n, cyc, {busy_o, err_o});
            end
            if (exp_valid) begin
                total_chk++;
                if ({tile_a_addr_o, tile_b_addr_o, tile_c_addr_o} !== {ea[idx], eb[idx], ec[idx]}
                    || {tile_first_k_o, tile_last_k_o, tile_load_c_o}
                       !== {efk[idx], elk[idx], elc[idx]}) begin
                    bad_chk++;
                    $display("FAIL desc n=%0d tile=%0d got=%h/%h/%h %b%b%b want=%h/%h/%h %b%b%b",
                             n, idx, tile_a_addr_o, tile_b_addr_o, tile_c_addr_o,
                             tile_first_k_o, tile_last_k_o, tile_load_c_o, ea[idx], eb[idx],
                             ec[idx], efk[idx], elk[idx], elc[idx]);
                end
            end
            if (exp_done) begin
                fin = 1;
                break;
            end
            if (abort_after >= 0 && idx == abort_after) break;
            rdy = ($urandom_range(99, 0) < 32'(ready_pct));
            if (exp_valid && idx == stall_idx && stall_left > 0) begin
                if (stall_left == stall_len) hold_a = tile_a_addr_o;
                else begin
                    total_chk++;
                    if (tile_a_addr_o !== hold_a) begin
                        bad_chk++;
                        $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, tile_a_addr_o,
                                 hold_a);
                    end
                end
                rdy = 1'b0;
                stall_left--;
            end
            tile_ready_i = rdy;
            hs = exp_valid && rdy;
            dn = (due.size() > 0) && (due[0] <= cyc);
            if (dn) void'(due.pop_front());
            tile_done_i = dn;
            if (hs) begin
                obs_a.push_back(tile_a_addr_o);
                obs_b.push_back(tile_b_addr_o);
                obs_c.push_back(tile_c_addr_o);
                obs_lk.push_back(tile_last_k_o);
                obs_lc.push_back(tile_load_c_o);
                last_due = (cyc + int'($urandom_range(max_delay, 1)) > last_due + 1) ?
                           cyc + int'($urandom_range(max_delay, 1)) : last_due + 1;
                due.push_back(last_due);
                idx++;
                last_hs = cyc;
            end
            outm = outm + int'(hs) - int'(dn);
            if (scramble) begin
                start_i      = 1'($urandom_range(1, 0));
                mat_dim_i    = 10'($urandom_range(1023, 0));
                mode_i       = 1'($urandom_range(1, 0));
                mat_a_addr_i = $urandom;
                mat_b_addr_i = $urandom;
                mat_c_addr_i = $urandom;
            end
            tick();
            cyc++;
        end
        start_i = 1'b0;
        tile_ready_i = 1'b0;
        tile_done_i = 1'b0;
        if (abort_after < 0) begin
            total_chk++;
            if (!fin) begin
                bad_chk++;
                $display("FAIL run_end n=%0d no done_o within budget got=0 want=1", n);
            end else begin
                tick();
                total_chk++;
                if ({busy_o, done_o, tile_valid_o} !== 3'b000) begin
                    bad_chk++;
                    $display("FAIL post_done n=%0d got=%b want=000", n,
                             {busy_o, done_o, tile_valid_o});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_chk++;
        if ({busy_o, done_o, err_o, tile_valid_o, tile_first_k_o, tile_last_k_o,
             tile_load_c_o} !== 7'b0) begin
            bad_chk++;
            $display("FAIL reset_flags got=%b want=0", {busy_o, done_o, err_o, tile_valid_o,
                     tile_first_k_o, tile_last_k_o, tile_load_c_o});
        end
        total_chk++;
        if ({tile_a_addr_o, tile_b_addr_o, tile_c_addr_o} !== 96'b0) begin
            bad_chk++;
            $display("FAIL reset_addr got=%h/%h/%h want=0", tile_a_addr_o, tile_b_addr_o,
                     tile_c_addr_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_tile();
        start_cmd(4, 1'b0, 32'h1000, 32'h2000, 32'h3000);
        total_chk++;
        if ({tile_valid_o, busy_o, tile_a_addr_o, tile_b_addr_o, tile_c_addr_o,
             tile_first_k_o, tile_last_k_o, tile_load_c_o}
            !== {2'b11, 32'h1000, 32'h2000, 32'h3000, 3'b110}) begin
            bad_chk++;
            $display("FAIL single_desc got=%b%b %h/%h/%h %b%b%b want=11 1000/2000/3000 110",
                     tile_valid_o, busy_o, tile_a_addr_o, tile_b_addr_o, tile_c_addr_o,
                     tile_first_k_o, tile_last_k_o, tile_load_c_o);
        end
        tile_ready_i = 1'b1;
        tick();
        tile_ready_i = 1'b0;
        total_chk++;
        if (tile_valid_o !== 1'b0) begin
            bad_chk++;
            $display("FAIL single_one_tile valid got=%b want=0", tile_valid_o);
        end
        tick();
        tick();
        total_chk++;
        if (done_o !== 1'b0) begin
            bad_chk++;
            $display("FAIL single_early_done got=%b want=0", done_o);
        end
        tile_done_i = 1'b1;
        tick();
        tile_done_i = 1'b0;
        total_chk++;
        if ({done_o, err_o, busy_o} !== 3'b101) begin
            bad_chk++;
            $display("FAIL single_done_t5 got=%b want=101", {done_o, err_o, busy_o});
        end
        tick();
        total_chk++;
        if ({done_o, busy_o} !== 2'b00) begin
            bad_chk++;
            $display("FAIL single_done_once got=%b want=00", {done_o, busy_o});
        end
    endtask

    task automatic test_n8_accum();
        run_cmd(8, 1'b1, 32'h1000, 32'h2000, 32'h3000, 100, 3, -1, -1, 0, 1'b0);
        total_chk++;
        if (obs_a.size() != 8) begin
            bad_chk++;
            $display("FAIL n8_count got=%0d want=8", obs_a.size());
        end else begin
            total_chk++;
            if ({obs_a[1], obs_b[1], obs_c[1], obs_lk[1], obs_lc[1]}
                !== {32'h1010, 32'h2080, 32'h3000, 2'b10}) begin
                bad_chk++;
                $display("FAIL n8_tile1 got=%h/%h/%h %b%b", obs_a[1], obs_b[1], obs_c[1],
                         obs_lk[1], obs_lc[1]);
            end
            total_chk++;
            if ({obs_a[2], obs_b[2], obs_c[2], obs_lc[2]}
                !== {32'h1000, 32'h2010, 32'h3010, 1'b1}) begin
                bad_chk++;
                $display("FAIL n8_tile2 got=%h/%h/%h %b", obs_a[2], obs_b[2], obs_c[2],
                         obs_lc[2]);
            end
            total_chk++;
            if (obs_c[7] !== 32'h3090) begin
                bad_chk++;
                $display("FAIL n8_tile7_c got=%h want=3090", obs_c[7]);
            end
        end
    endtask

    task automatic test_backpressure();
        run_cmd(8, 1'b0, $urandom, $urandom, $urandom, 100, 2, -1, 3, 5, 1'b0);
        total_chk++;
        if (obs_a.size() != 8) begin
            bad_chk++;
            $display("FAIL bp_count got=%0d want=8", obs_a.size());
        end
    endtask

    task automatic test_out_limit();
        logic [31:0] ab;
        logic        want[9];
        int          done_at[3];
        ab = $urandom;
        // Expected valid for cycles 1..8, with done pulses in cycles 4, 6 and 7.
        want = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        done_at = '{4, 6, 7};
        start_cmd(8, 1'b0, ab, 32'h0, 32'h0);
        tile_ready_i = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            total_chk++;
            if (tile_valid_o !== ((c == 9) ? 1'b0 : want[c])) begin
                bad_chk++;
                $display("FAIL outlim_valid cyc=%0d got=%b want=%b", c, tile_valid_o,
                         (c == 9) ? 1'b0 : want[c]);
            end
            if (c == 8) begin
                total_chk++;
                if (tile_a_addr_o !== taddr(ab, 1, 0, 8)) begin
                    bad_chk++;
                    $display("FAIL outlim_tile4 got=%h want=%h", tile_a_addr_o,
                             taddr(ab, 1, 0, 8));
                end
            end
            tile_done_i = (c == done_at[0]) || (c == done_at[1]) || (c == done_at[2]);
            tick();
        end
        tile_done_i  = 1'b0;
        tile_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        int bad_n[2];
        bad_n = '{6, 0};
        for (int i = 0; i < 2; i++) begin
            start_cmd(bad_n[i], 1'b0, 32'h1000, 32'h2000, 32'h3000);
            total_chk++;
            if ({tile_valid_o, done_o, err_o} !== 3'b011) begin
                bad_chk++;
                $display("FAIL illegal_t1 n=%0d got=%b want=011", bad_n[i],
                         {tile_valid_o, done_o, err_o});
            end
            tick();
            total_chk++;
            if ({tile_valid_o, done_o, err_o} !== 3'b001) begin
                bad_chk++;
                $display("FAIL illegal_t2 n=%0d got=%b want=001", bad_n[i],
                         {tile_valid_o, done_o, err_o});
            end
        end
        // Legal start clears err_o; run_cmd checks err_o every cycle.
        run_cmd(4, 1'b1, 32'h10, 32'h20, 32'h30, 100, 1, -1, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_cmd(8, 1'b1, $urandom, $urandom, $urandom, 100, 6, 3, -1, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_chk++;
        if ({busy_o, done_o, err_o, tile_valid_o, tile_first_k_o, tile_last_k_o,
             tile_load_c_o, tile_a_addr_o, tile_b_addr_o, tile_c_addr_o} !== 103'b0) begin
            bad_chk++;
            $display("FAIL rst_mid_outputs got=%b%b%b%b %h/%h/%h want=0", busy_o, done_o,
                     err_o, tile_valid_o, tile_a_addr_o, tile_b_addr_o, tile_c_addr_o);
        end
        // Completions of the aborted tiles arrive late and must be ignored.
        for (int c = 0; c < 4; c++) begin
            tile_done_i = 1'b1;
            tick();
            total_chk++;
            if ({done_o, busy_o, tile_valid_o} !== 3'b000) begin
                bad_chk++;
                $display("FAIL rst_mid_quiet cyc=%0d got=%b want=000", c,
                         {done_o, busy_o, tile_valid_o});
            end
        end
        tile_done_i = 1'b0;
        tick();
        run_cmd(8, 1'b0, $urandom, $urandom, $urandom, 100, 4, -1, -1, 0, 1'b0);
        total_chk++;
        if (obs_a.size() != 8) begin
            bad_chk++;
            $display("FAIL rst_mid_rerun_count got=%0d want=8", obs_a.size());
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(8, 1'b1, $urandom, $urandom, $urandom, 100, 1, -1, -1, 0, 1'b0);
        run_cmd(12, 1'b0, $urandom, $urandom, $urandom, 100, 1, -1, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        int dims[4];
        dims = '{4, 8, 12, 16};
        for (int i = 0; i < 6; i++) begin
            run_cmd(dims[$urandom_range(3, 0)], 1'($urandom_range(1, 0)), $urandom, $urandom,
                    $urandom, int'($urandom_range(100, 30)), int'($urandom_range(8, 1)), -1,
                    -1, 0, 1'b1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        mat_dim_i    = '0;
        mode_i       = 1'b0;
        mat_a_addr_i = '0;
        mat_b_addr_i = '0;
        mat_c_addr_i = '0;
        tile_ready_i = 1'b0;
        tile_done_i  = 1'b0;
        test_reset();
        test_single_tile();
        test_n8_accum();
        test_backpressure();
        test_out_limit();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
        $finish;
    end

endmodule
